instruction_sequencer: RTL
==========================

Name: instruction_sequencer

Overview:
Fetch/issue controller that drives the PC of the instruction memory and sequences its 256-bit instruction words into the MAC-engine datapath.
- Issues each instruction with a valid/ready handshake.
- Waits for the datapath's execution-done.
- Repeats the instruction per its repeat field, then advances until an instruction with the last flag completes.
- Gates external instruction-memory writes so the program cannot be modified while running.

Parameters:
IM_SIZE, 2, number of instruction words in instruction memory
IM_FIELDS, 8, 32-bit fields per instruction word
IM_WIDTH, 32, bits per field
PC_WIDTH, 32, width of PC and start address
REP_WIDTH, 16, width of repeat count in field 0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse: begin program at start_addr (ignored unless IDLE)
start_addr  in  PC_WIDTH  first instruction index
PC  out  PC_WIDTH  instruction-memory read address
instruction  in  IM_FIELDS*IM_WIDTH  combinational read data for PC
instr_out  out  IM_FIELDS*IM_WIDTH  registered instruction presented to datapath
instr_valid  out  1  instr_out valid
instr_ready  in  1  datapath accepts instr_out
exec_done  in  1  datapath finished the accepted instruction (1-cycle pulse)
iter_idx  out  REP_WIDTH  current repetition index of issued instruction
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse at program completion
error  out  1  sticky; PC overran IM_SIZE-1 without last flag; cleared by start
wr_en_ext_req  in  1  external write request to instruction memory
wr_en_ext_im  out  1  gated write enable = wr_en_ext_req & ~busy
wr_reject  out  1  1-cycle pulse when wr_en_ext_req arrives while busy

Behaviour:
- Field 0 of instruction (bits [31:0]) is decoded:
  - bit 31 = LAST.
  - bits [REP_WIDTH-1:0] = REPEAT. Executions = REPEAT+1, so 0 means one execution.
  - Remaining fields pass through untouched.
- Reset values: PC=0, instr_out=0, instr_valid=0, iter_idx=0, busy=0, done=0, error=0, wr_reject=0; state IDLE.
- States:
  - IDLE: start -> PC<=start_addr, error<=0, iter_idx<=0, go FETCH.
  - FETCH: one cycle. Instruction for current PC is sampled into instr_out, LAST and REPEAT are latched internally, instr_valid<=1, go ISSUE.
  - ISSUE: hold instr_valid and instr_out stable until instr_ready. On valid&ready: instr_valid<=0, go EXEC.
  - EXEC: wait for exec_done.
    - If iter_idx<REPEAT: iter_idx+1, instr_valid<=1, go ISSUE. Same instr_out; no refetch.
    - Else if LAST: done<=1, go IDLE.
    - Else if PC==IM_SIZE-1: error<=1, done<=1, go IDLE.
    - Else: PC+1, iter_idx<=0, go FETCH.
- Latency: start to first instr_valid = 2 cycles. exec_done to next instr_valid = 1 cycle for a repeat, 2 cycles for a new instruction.
- exec_done is ignored outside EXEC. instr_ready is ignored while instr_valid=0.
- start while busy: ignored, no effect on PC or state.
- start_addr>=IM_SIZE: error<=1 and done pulse in the same cycle as start; stays IDLE.
- Write gating (combinational, all states):
  - wr_en_ext_im = wr_en_ext_req & ~busy.
  - wr_reject (registered) = wr_en_ext_req & busy.
  - A write request in the same cycle as start is allowed; busy is still 0.
- Reset asserted mid-program: immediate return to IDLE. All outputs return to reset values and the in-flight instruction is dropped; no done pulse.
- iter_idx arithmetic is unsigned REP_WIDTH. REPEAT=all-ones gives 2^REP_WIDTH executions without overflow, because the compare happens before increment.
- PC changes only in IDLE (on start) and on the EXEC->FETCH transition.

Decomposition:
- Shared MAC-engine parameters package holds:
  - IM_SIZE, IM_FIELDS, IM_WIDTH.
  - LAST_BIT=31, REP_LSB=0.
  - Sequencer state enum (IDLE, FETCH, ISSUE, EXEC).
- Single module; no sub-module needed. The write gate is a few lines inside it.

Test Plan:
- Single instruction: mem[0].field0=0x8000_0000, start_addr=0, ready tied 1, exec_done 3 cycles after accept -> exactly one valid handshake; instr_out equals mem[0]; done pulses once; PC=0; error=0.
- Repeat and advance: mem[0].field0=0x0000_0002, mem[1].field0=0x8000_0000 -> mem[0] issued 3 times with iter_idx 0,1,2; then mem[1] once; done pulse; PC ends at 1.
- Backpressure: instr_ready low 5 cycles after valid -> instr_valid and instr_out held stable for 5 cycles; single accept when ready rises; no duplicate issue.
- Overrun: mem[0] and mem[1] field0=0 (no LAST) -> after mem[1] exec_done: error=1, done pulse, busy=0. A following start clears error.
- Write gating: wr_en_ext_req pulsed while busy -> wr_en_ext_im=0 and wr_reject=1. Same request in IDLE -> wr_en_ext_im=1 and wr_reject=0.
- Reset mid-EXEC: assert reset during EXEC -> next edge busy=0, instr_valid=0, PC=0, no done. A later start runs normally.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared MAC-engine parameters for the instruction sequencer.
// Holds the instruction-memory geometry, the field-0 decode positions and
// the sequencer state encoding.
package instruction_sequencer_pkg;

  localparam int IM_SIZE   = 2;   // instruction words in instruction memory
  localparam int IM_FIELDS = 8;   // 32-bit fields per instruction word
  localparam int IM_WIDTH  = 32;  // bits per field

  localparam int LAST_BIT  = 31;  // field 0: end-of-program flag
  localparam int REP_LSB   = 0;   // field 0: repeat count starts here

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    EXEC
  } seq_state_e;

endpackage

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Fetch/issue controller for the MAC engine. Drives the instruction-memory
// PC, registers each 256-bit instruction word, hands it to the datapath
// with a valid/ready handshake, waits for exec_done, repeats the word
// REPEAT+1 times and advances until a word flagged LAST completes.
// External instruction-memory writes are blocked while a program runs.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, start_addr   start pulse and first instruction index
//   PC                  instruction-memory read address
//   instruction         combinational read data at PC
//   instr_out           registered instruction to the datapath
//   instr_valid/ready   issue handshake
//   exec_done           datapath finished accepted instruction (pulse)
//   iter_idx            repetition index of the issued instruction
//   busy, done, error   status (done is a pulse, error is sticky)
//   wr_en_ext_req/_im   external write request / gated write enable
//   wr_reject           pulse when a write request arrives while busy
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int REP_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [PC_WIDTH-1:0]           start_addr,
  output logic [PC_WIDTH-1:0]           PC,
  input  logic [IM_FIELDS*IM_WIDTH-1:0] instruction,
  output logic [IM_FIELDS*IM_WIDTH-1:0] instr_out,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  input  logic                          exec_done,
  output logic [REP_WIDTH-1:0]          iter_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  input  logic                          wr_en_ext_req,
  output logic                          wr_en_ext_im,
  output logic                          wr_reject
);

  localparam int INSTR_W = IM_FIELDS * IM_WIDTH;

  seq_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 vld_q, vld_d;
  logic [REP_WIDTH-1:0] iter_q, iter_d;
  logic [REP_WIDTH-1:0] rep_q, rep_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 wr_reject_q;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    iter_d  = iter_q;
    rep_d   = rep_q;
    last_d  = last_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_addr >= PC_WIDTH'(IM_SIZE)) begin
            // Bad entry point: report and complete without running.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            pc_d    = start_addr;
            err_d   = 1'b0;
            iter_d  = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        instr_d = instruction;
        last_d  = instruction[LAST_BIT];
        rep_d   = instruction[REP_LSB +: REP_WIDTH];
        vld_d   = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (instr_ready) begin
          vld_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          // Compare before increment so REPEAT=all-ones never wraps iter.
          if (iter_q < rep_q) begin
            iter_d  = iter_q + REP_WIDTH'(1);
            vld_d   = 1'b1;
            state_d = ISSUE;
          end else if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (pc_q == PC_WIDTH'(IM_SIZE - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pc_d    = pc_q + PC_WIDTH'(1);
            iter_d  = '0;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      vld_q       <= 1'b0;
      iter_q      <= '0;
      rep_q       <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      vld_q       <= vld_d;
      iter_q      <= iter_d;
      rep_q       <= rep_d;
      last_q      <= last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_reject_q <= wr_en_ext_req & busy;
    end
  end

  // Write gate is purely combinational so a request coincident with start
  // still goes through: busy only rises on the following edge.
  assign wr_en_ext_im = wr_en_ext_req & ~busy;
  assign wr_reject    = wr_reject_q;

  assign PC          = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = vld_q;
  assign iter_idx    = iter_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule
